// File: rtl/fetch_sequencer_pkg.sv
// Shared widths, opcode constants, FSM encodings and the PC look-ahead helper
// for the instruction fetch sequencer.
package fetch_sequencer_pkg;

   localparam int ADDR_WIDTH = 8;
   localparam int DATA_WIDTH = 16;
   localparam int OPC_WIDTH  = 4;
   localparam int CNT_WIDTH  = 16;

   localparam logic [OPC_WIDTH-1:0] HALT_OPC = 4'hF;

   typedef logic [2:0] fs_state_t;

   localparam fs_state_t FS_IDLE     = 3'd0;
   localparam fs_state_t FS_FETCH    = 3'd1;
   localparam fs_state_t FS_HOLD     = 3'd2;
   localparam fs_state_t FS_DRAIN    = 3'd3;
   localparam fs_state_t FS_REDIRECT = 3'd4;
   localparam fs_state_t FS_HALTED   = 3'd5;

   // Value the PC will hold after the current edge, given the pulses we are
   // driving to it this cycle. A load always takes precedence over an increment.
   function automatic logic [ADDR_WIDTH-1:0] pc_next(
      input logic [ADDR_WIDTH-1:0] pc,
      input logic                  inc,
      input logic                  load,
      input logic [ADDR_WIDTH-1:0] dest
   );
      logic [ADDR_WIDTH-1:0] nxt;
      nxt = pc;
      if (load)
         nxt = dest;
      else if (inc)
         nxt = pc + 1'b1;
      return nxt;
   endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle of PC, memory, downstream and branch signals around the fetch
// sequencer; master is the sequencer, slave is the surrounding system.
interface fetch_sequencer_if;
   import fetch_sequencer_pkg::*;

   logic                  Run;
   logic [ADDR_WIDTH-1:0] PC_Out;
   logic                  PC_Inc;
   logic                  PC_Load;
   logic [ADDR_WIDTH-1:0] Dest_Reg;
   logic                  Mem_Req;
   logic [ADDR_WIDTH-1:0] Mem_Addr;
   logic                  Mem_Ack;
   logic [DATA_WIDTH-1:0] Mem_Data;
   logic [DATA_WIDTH-1:0] Instr_Out;
   logic                  Instr_Valid;
   logic                  Instr_Ready;
   logic                  Branch_Taken;
   logic [ADDR_WIDTH-1:0] Branch_Target;
   logic                  Halted;
   logic [CNT_WIDTH-1:0]  Fetch_Count;

   // Handshakes: Mem_Req/Mem_Addr stay stable until a one-cycle Mem_Ack, whose
   // Mem_Data is valid in that same cycle. Instr_Out transfers on any rising edge
   // with Instr_Valid & Instr_Ready; Instr_Out is stable while valid and unaccepted.
   modport master (
      input  Run, PC_Out, Mem_Ack, Mem_Data, Instr_Ready, Branch_Taken, Branch_Target,
      output PC_Inc, PC_Load, Dest_Reg, Mem_Req, Mem_Addr, Instr_Out, Instr_Valid,
             Halted, Fetch_Count
   );

   modport slave (
      output Run, PC_Out, Mem_Ack, Mem_Data, Instr_Ready, Branch_Taken, Branch_Target,
      input  PC_Inc, PC_Load, Dest_Reg, Mem_Req, Mem_Addr, Instr_Out, Instr_Valid,
             Halted, Fetch_Count
   );

endinterface

// File: rtl/fetch_skid.sv
// Instruction holding register with its valid flag and the count of
// instructions accepted downstream.
module fetch_skid
   import fetch_sequencer_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_flush,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   output logic [CNT_WIDTH-1:0]  o_count,
   output logic                  o_xfer
);

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic [CNT_WIDTH-1:0]  r_count;
   logic                  w_xfer;

   // A flush drops the held word without counting it, even if ready is high.
   assign w_xfer = r_valid & i_ready & ~i_flush;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_count <= '0;
      end else begin
         if (i_flush) begin
            r_valid <= 1'b0;
         end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
         end else if (w_xfer) begin
            r_valid <= 1'b0;
            r_count <= r_count + 1'b1;
         end
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;
   assign o_count = r_count;
   assign o_xfer  = w_xfer;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch FSM: reads the PC, fetches over req/ack, hands instructions downstream
// and drives PC increment/load pulses, including branch redirects and HALT.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
(
   input  logic                 Clk,
   input  logic                 Clr,
   fetch_sequencer_if.master    bus,
   output logic [2:0]           o_dbg_state
);

   fs_state_t             r_state;
   logic                  r_pc_inc;
   logic                  r_pc_load;
   logic [ADDR_WIDTH-1:0] r_dest_reg;
   logic                  r_mem_req;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic                  r_halted;

   logic                  w_in_fetch;
   logic                  w_in_hold;
   logic                  w_branch;
   logic                  w_flush;
   logic                  w_load;
   logic                  w_xfer;
   logic                  w_valid;
   logic [DATA_WIDTH-1:0] w_instr;
   logic [CNT_WIDTH-1:0]  w_count;
   logic [ADDR_WIDTH-1:0] w_next_addr;
   logic                  w_is_halt;

   assign w_in_fetch = (r_state == FS_FETCH);
   assign w_in_hold  = (r_state == FS_HOLD);
   assign w_branch   = bus.Branch_Taken;
   assign w_flush    = w_branch & (w_in_fetch | w_in_hold);
   assign w_load     = w_in_fetch & bus.Mem_Ack & ~w_branch;
   assign w_is_halt  = (w_instr[DATA_WIDTH-1 -: OPC_WIDTH] == HALT_OPC);

   // PC_Out still shows the old value on the edge where our inc/load pulse is
   // applied, so a fetch entered on that edge uses the PC's next value instead.
   assign w_next_addr = pc_next(bus.PC_Out, r_pc_inc, r_pc_load, r_dest_reg);

   fetch_skid u_skid (
      .i_clk   (Clk),
      .i_rst   (Clr),
      .i_load  (w_load),
      .i_data  (bus.Mem_Data),
      .i_flush (w_flush),
      .i_ready (bus.Instr_Ready),
      .o_data  (w_instr),
      .o_valid (w_valid),
      .o_count (w_count),
      .o_xfer  (w_xfer)
   );

   always_ff @(posedge Clk or posedge Clr) begin
      if (Clr) begin
         r_state    <= FS_IDLE;
         r_pc_inc   <= 1'b0;
         r_pc_load  <= 1'b0;
         r_dest_reg <= '0;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
         r_halted   <= 1'b0;
      end else begin
         r_pc_inc  <= 1'b0;
         r_pc_load <= 1'b0;
         case (r_state)
            FS_IDLE: begin
               if (bus.Run) begin
                  r_state    <= FS_FETCH;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= w_next_addr;
               end
            end
            FS_FETCH: begin
               if (w_branch) begin
                  r_pc_load  <= 1'b1;
                  r_dest_reg <= bus.Branch_Target;
                  if (bus.Mem_Ack) begin
                     r_mem_req <= 1'b0;
                     r_state   <= FS_REDIRECT;
                  end else begin
                     r_state   <= FS_DRAIN;
                  end
               end else if (bus.Mem_Ack) begin
                  r_mem_req <= 1'b0;
                  r_pc_inc  <= 1'b1;
                  r_state   <= FS_HOLD;
               end
            end
            FS_HOLD: begin
               if (w_branch) begin
                  r_pc_load  <= 1'b1;
                  r_dest_reg <= bus.Branch_Target;
                  r_state    <= FS_REDIRECT;
               end else if (w_xfer) begin
                  if (w_is_halt) begin
                     r_halted <= 1'b1;
                     r_state  <= FS_HALTED;
                  end else begin
                     r_mem_req  <= 1'b1;
                     r_mem_addr <= w_next_addr;
                     r_state    <= FS_FETCH;
                  end
               end
            end
            FS_DRAIN: begin
               // Request stays up on the old address until the stale word returns.
               if (w_branch) begin
                  r_pc_load  <= 1'b1;
                  r_dest_reg <= bus.Branch_Target;
                  if (bus.Mem_Ack) begin
                     r_mem_req <= 1'b0;
                     r_state   <= FS_REDIRECT;
                  end
               end else if (bus.Mem_Ack) begin
                  r_mem_addr <= w_next_addr;
                  r_state    <= FS_FETCH;
               end
            end
            FS_REDIRECT: begin
               if (w_branch) begin
                  r_pc_load  <= 1'b1;
                  r_dest_reg <= bus.Branch_Target;
               end else begin
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= w_next_addr;
                  r_state    <= FS_FETCH;
               end
            end
            FS_HALTED: begin
               r_mem_req <= 1'b0;
            end
            default: begin
               r_mem_req <= 1'b0;
               r_state   <= FS_IDLE;
            end
         endcase
      end
   end

   assign bus.PC_Inc      = r_pc_inc;
   assign bus.PC_Load     = r_pc_load;
   assign bus.Dest_Reg    = r_dest_reg;
   assign bus.Mem_Req     = r_mem_req;
   assign bus.Mem_Addr    = r_mem_addr;
   assign bus.Instr_Out   = w_instr;
   assign bus.Instr_Valid = w_valid;
   assign bus.Halted      = r_halted;
   assign bus.Fetch_Count = w_count;
   assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an attached PC model and a
// variable-latency instruction memory model.
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   logic       Clk = 1'b0;
   logic       Clr = 1'b1;
   logic [2:0] dbg_state;

   fetch_sequencer_if bus ();

   fetch_sequencer dut (
      .Clk         (Clk),
      .Clr         (Clr),
      .bus         (bus.master),
      .o_dbg_state (dbg_state)
   );

   always #5 Clk = ~Clk;

   // ---------------- environment models ----------------
   logic [7:0]  pc_q       = 8'h00;
   logic        mem_ack_m  = 1'b0;
   logic [15:0] mem_data_m = 16'h0000;
   logic        ack_force  = 1'b0;
   int          ack_delay  = 0;
   int          wait_cnt   = 0;
   int          inc_cnt    = 0;
   int          both_hi    = 0;

   assign bus.PC_Out   = pc_q;
   assign bus.Mem_Ack  = mem_ack_m | ack_force;
   assign bus.Mem_Data = mem_data_m;

   function automatic logic [15:0] mem_word(input logic [7:0] a);
      case (a)
         8'h00:   return 16'h1234;
         8'h03:   return 16'hF000;
         default: return 16'hA000 | {8'h00, a};
      endcase
   endfunction

   always @(posedge Clk) begin
      if (bus.PC_Load)
         pc_q <= bus.Dest_Reg;
      else if (bus.PC_Inc)
         pc_q <= pc_q + 8'd1;
   end

   always @(posedge Clk) begin
      if (bus.Mem_Req && !mem_ack_m) begin
         if (wait_cnt >= ack_delay) begin
            mem_ack_m  <= 1'b1;
            mem_data_m <= mem_word(bus.Mem_Addr);
         end else begin
            wait_cnt <= wait_cnt + 1;
         end
      end else begin
         mem_ack_m <= 1'b0;
         wait_cnt  <= 0;
      end
   end

   always @(posedge Clk) begin
      if (bus.PC_Inc)
         inc_cnt <= inc_cnt + 1;
      if (bus.PC_Inc && bus.PC_Load)
         both_hi <= both_hi + 1;
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else
         n_pass++;
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n;
      n = 0;
      while (!bus.Instr_Valid && n < budget) begin
         @(negedge Clk);
         n++;
      end
      check(tag, 32'(bus.Instr_Valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin
      logic saw_valid;
      logic saw_activity;
      int   n;

      bus.Run           = 1'b0;
      bus.Instr_Ready   = 1'b0;
      bus.Branch_Taken  = 1'b0;
      bus.Branch_Target = 8'h00;

      // Reset values
      @(negedge Clk);
      check("rst_state",  32'(dbg_state),       32'(FS_IDLE));
      check("rst_req",    32'(bus.Mem_Req),     32'd0);
      check("rst_addr",   32'(bus.Mem_Addr),    32'd0);
      check("rst_valid",  32'(bus.Instr_Valid), 32'd0);
      check("rst_instr",  32'(bus.Instr_Out),   32'd0);
      check("rst_inc",    32'(bus.PC_Inc),      32'd0);
      check("rst_load",   32'(bus.PC_Load),     32'd0);
      check("rst_halted", 32'(bus.Halted),      32'd0);
      check("rst_count",  32'(bus.Fetch_Count), 32'd0);
      Clr = 1'b0;

      // Basic fetch at 0x00, immediate ack, ready high
      ack_delay       = 0;
      bus.Instr_Ready = 1'b1;
      bus.Run         = 1'b1;
      @(negedge Clk);
      bus.Run = 1'b0;
      check("f1_req",  32'(bus.Mem_Req),  32'd1);
      check("f1_addr", 32'(bus.Mem_Addr), 32'h00);
      @(negedge Clk);
      @(negedge Clk);
      check("f1_valid", 32'(bus.Instr_Valid), 32'd1);
      check("f1_instr", 32'(bus.Instr_Out),   32'h1234);
      check("f1_inc",   32'(bus.PC_Inc),      32'd1);
      @(negedge Clk);
      check("f1_count",    32'(bus.Fetch_Count), 32'd1);
      check("f1_next_adr", 32'(bus.Mem_Addr),    32'h01);
      check("f1_next_req", 32'(bus.Mem_Req),     32'd1);
      check("f1_inc_off",  32'(bus.PC_Inc),      32'd0);
      check("f1_inc_cnt",  32'(inc_cnt),         32'd1);
      check("f1_pc",       32'(pc_q),            32'h01);

      // Backpressure: ready low for 5 cycles
      bus.Instr_Ready = 1'b0;
      wait_valid("bp_wait", 10);
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         check("bp_valid", 32'(bus.Instr_Valid), 32'd1);
         check("bp_instr", 32'(bus.Instr_Out),   32'hA001);
         check("bp_req",   32'(bus.Mem_Req),     32'd0);
         check("bp_count", 32'(bus.Fetch_Count), 32'd1);
      end
      check("bp_inc_cnt", 32'(inc_cnt), 32'd2);
      check("bp_pc",      32'(pc_q),    32'h02);
      bus.Instr_Ready = 1'b1;
      @(negedge Clk);
      check("bp_count2", 32'(bus.Fetch_Count), 32'd2);
      check("bp_valid0", 32'(bus.Instr_Valid), 32'd0);
      check("bp_addr2",  32'(bus.Mem_Addr),    32'h02);

      // Branch while request pending, ack delayed 3 cycles
      ack_delay         = 3;
      bus.Branch_Taken  = 1'b1;
      bus.Branch_Target = 8'h40;
      @(negedge Clk);
      bus.Branch_Taken = 1'b0;
      bus.Instr_Ready  = 1'b0;
      check("br_load",  32'(bus.PC_Load),  32'd1);
      check("br_dest",  32'(bus.Dest_Reg), 32'h40);
      check("br_req",   32'(bus.Mem_Req),  32'd1);
      check("br_oaddr", 32'(bus.Mem_Addr), 32'h02);
      check("br_state", 32'(dbg_state),    32'(FS_DRAIN));
      @(negedge Clk);
      check("br_load1", 32'(bus.PC_Load), 32'd0);
      saw_valid = 1'b0;
      n = 0;
      while (dbg_state != FS_FETCH && n < 10) begin
         @(negedge Clk);
         if (bus.Instr_Valid) saw_valid = 1'b1;
         n++;
      end
      check("br_refetch", 32'(dbg_state),    32'(FS_FETCH));
      check("br_discard", 32'(saw_valid),    32'd0);
      check("br_naddr",   32'(bus.Mem_Addr), 32'h40);
      check("br_nreq",    32'(bus.Mem_Req),  32'd1);
      ack_delay = 0;

      // Branch in the first HOLD cycle while PC_Inc is high
      wait_valid("bh_wait", 10);
      check("bh_instr", 32'(bus.Instr_Out), 32'hA040);
      check("bh_inc",   32'(bus.PC_Inc),    32'd1);
      bus.Branch_Taken  = 1'b1;
      bus.Branch_Target = 8'h10;
      @(negedge Clk);
      bus.Branch_Taken = 1'b0;
      check("bh_inc0",  32'(bus.PC_Inc),      32'd0);
      check("bh_load",  32'(bus.PC_Load),     32'd1);
      check("bh_dest",  32'(bus.Dest_Reg),    32'h10);
      check("bh_valid", 32'(bus.Instr_Valid), 32'd0);
      check("bh_state", 32'(dbg_state),       32'(FS_REDIRECT));
      check("bh_count", 32'(bus.Fetch_Count), 32'd2);
      @(negedge Clk);
      check("bh_pc",    32'(pc_q),         32'h10);
      check("bh_addr",  32'(bus.Mem_Addr), 32'h10);
      check("bh_fetch", 32'(dbg_state),    32'(FS_FETCH));
      check("bh_both",  32'(both_hi),      32'd0);

      // Redirect to 0x03, which holds a HALT
      bus.Branch_Taken  = 1'b1;
      bus.Branch_Target = 8'h03;
      bus.Instr_Ready   = 1'b1;
      @(negedge Clk);
      bus.Branch_Taken = 1'b0;
      wait_valid("ht_wait", 10);
      check("ht_instr", 32'(bus.Instr_Out), 32'hF000);
      @(negedge Clk);
      check("ht_halted", 32'(bus.Halted),      32'd1);
      check("ht_state",  32'(dbg_state),       32'(FS_HALTED));
      check("ht_count",  32'(bus.Fetch_Count), 32'd3);
      check("ht_valid",  32'(bus.Instr_Valid), 32'd0);
      saw_activity = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bus.Branch_Taken  = (i % 3 == 0);
         bus.Branch_Target = 8'h55;
         bus.Run           = 1'b1;
         @(negedge Clk);
         if (bus.Mem_Req || bus.PC_Inc || bus.PC_Load) saw_activity = 1'b1;
      end
      bus.Branch_Taken = 1'b0;
      bus.Run          = 1'b0;
      check("ht_quiet",   32'(saw_activity),     32'd0);
      check("ht_state2",  32'(dbg_state),        32'(FS_HALTED));
      check("ht_count2",  32'(bus.Fetch_Count),  32'd3);
      check("ht_pc",      32'(pc_q),             32'h04);

      // Clr exits HALTED; then asynchronous Clr in the middle of a FETCH
      Clr = 1'b1;
      @(negedge Clk);
      Clr = 1'b0;
      check("cl_state", 32'(dbg_state),  32'(FS_IDLE));
      check("cl_halt",  32'(bus.Halted), 32'd0);
      ack_delay = 3;
      bus.Run   = 1'b1;
      @(negedge Clk);
      bus.Run = 1'b0;
      check("cl_req",  32'(bus.Mem_Req),  32'd1);
      check("cl_addr", 32'(bus.Mem_Addr), 32'h04);
      #2;
      Clr = 1'b1;
      #1;
      check("cl_async_req",   32'(bus.Mem_Req),     32'd0);
      check("cl_async_addr",  32'(bus.Mem_Addr),    32'd0);
      check("cl_async_state", 32'(dbg_state),       32'(FS_IDLE));
      check("cl_async_count", 32'(bus.Fetch_Count), 32'd0);
      @(negedge Clk);
      Clr       = 1'b0;
      ack_force = 1'b1;
      @(negedge Clk);
      ack_force = 1'b0;
      check("cl_stray_state", 32'(dbg_state),       32'(FS_IDLE));
      check("cl_stray_valid", 32'(bus.Instr_Valid), 32'd0);
      check("cl_stray_inc",   32'(bus.PC_Inc),      32'd0);
      check("cl_stray_req",   32'(bus.Mem_Req),     32'd0);

      // Restart from the untouched PC
      ack_delay       = 0;
      bus.Instr_Ready = 1'b1;
      bus.Run         = 1'b1;
      @(negedge Clk);
      bus.Run = 1'b0;
      check("rs_addr", 32'(bus.Mem_Addr), 32'h04);
      wait_valid("rs_wait", 10);
      check("rs_instr", 32'(bus.Instr_Out), 32'hA004);
      @(negedge Clk);
      check("rs_count", 32'(bus.Fetch_Count), 32'd1);
      check("rs_pc",    32'(pc_q),            32'h05);
      check("end_both", 32'(both_hi),         32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Consumer and controller of the program counter. Reads PC_Out and fetches the instruction at that address over a req/ack memory port.
- Presents the instruction downstream through a valid/ready handshake.
- Drives the PC's PC_Inc and PC_Load/Dest_Reg controls back, including branch redirects.
- Sits between the PC, instruction memory and the decode/execute stage.

Parameters:
- ADDR_WIDTH, 8: PC / memory address width (shared `ADDR_WIDTH).
- DATA_WIDTH, 16: instruction word width.
- OPC_WIDTH, 4: opcode field width, bits [DATA_WIDTH-1 -: OPC_WIDTH].
- HALT_OPC, 4'hF: opcode that stops fetching.
- CNT_WIDTH, 16: fetch counter width.

Ports:
- Clk  in  1  clock, rising edge.
- Clr  in  1  reset, asynchronous, active-high.
- Run  in  1  start fetching from IDLE.
- PC_Out  in  ADDR_WIDTH  current PC value.
- PC_Inc  out  1  one-cycle increment pulse to PC.
- PC_Load  out  1  one-cycle load pulse to PC.
- Dest_Reg  out  ADDR_WIDTH  branch target driven to PC.
- Mem_Req  out  1  memory read request.
- Mem_Addr  out  ADDR_WIDTH  read address.
- Mem_Ack  in  1  one-cycle read acknowledge; data valid the same cycle.
- Mem_Data  in  DATA_WIDTH  read data.
- Instr_Out  out  DATA_WIDTH  fetched instruction.
- Instr_Valid  out  1  Instr_Out valid.
- Instr_Ready  in  1  downstream accepts.
- Branch_Taken  in  1  redirect pulse from execute.
- Branch_Target  in  ADDR_WIDTH  redirect address.
- Halted  out  1  HALT reached.
- Fetch_Count  out  CNT_WIDTH  count of accepted instructions.

Behaviour:
- Reset (async, while Clr=1):
  - State=IDLE.
  - All outputs 0: PC_Inc, PC_Load, Dest_Reg, Mem_Req, Mem_Addr, Instr_Out, Instr_Valid, Halted, Fetch_Count.
  - Clr mid-transaction abandons it; a later stray Mem_Ack is ignored in IDLE.
- All outputs are registered.
- IDLE: Run=1 -> FETCH next edge.
- FETCH:
  - Mem_Req=1, Mem_Addr=PC_Out.
  - Mem_Req and Mem_Addr are held stable until Mem_Ack.
  - On Mem_Ack: Instr_Out<=Mem_Data, Instr_Valid<=1, PC_Inc<=1 (exactly one cycle), Mem_Req<=0 -> HOLD.
  - Fetch latency is 2 cycles minimum (req cycle plus ack cycle when Ack is immediate).
- HOLD:
  - PC_Inc is high in the first HOLD cycle only; the PC advances on that edge.
  - Transfer occurs on an edge with Instr_Valid&Instr_Ready. At the transfer: Instr_Valid<=0, Fetch_Count+=1 (wraps modulo 2^CNT_WIDTH).
  - After transfer, the next state is FETCH, or HALTED if opcode==HALT_OPC.
  - Instr_Ready may be high in the first HOLD cycle. The next FETCH then samples the already-incremented PC.
  - Instr_Out is stable while Valid=1 and not accepted.
- Branch_Taken=1 in FETCH/HOLD (priority over Ack and handshake, below Clr):
  - Instr_Valid<=0; the held instruction is dropped and not counted.
  - PC_Inc forced 0.
  - PC_Load<=1 and Dest_Reg<=Branch_Target for exactly one cycle.
  - Next state:
    - FETCH with Mem_Ack=0 -> DRAIN.
    - FETCH with Mem_Ack=1, or HOLD -> REDIRECT.
  - A Branch_Taken during HOLD in the cycle PC_Inc is high: the load wins; PC_Inc and PC_Load must never both be 1.
- DRAIN: Mem_Req stays 1 with the old Mem_Addr until Mem_Ack. The returned data is discarded -> FETCH.
- REDIRECT: one cycle, allowing the PC load to settle -> FETCH.
- Branch_Taken in DRAIN/REDIRECT: the new target supersedes; PC_Load is re-pulsed with the new Dest_Reg and the state is kept.
- HALTED: Halted=1. Mem_Req, PC_Inc and PC_Load are held 0. Branch_Taken and Run are ignored. Exit only via Clr.
- Run is sampled only in IDLE.

Decomposition:
- Shared parameters file (existing `ADDR_WIDTH etc.) gains:
  - `DATA_WIDTH, `OPC_WIDTH, `HALT_OPC.
  - State encodings FS_IDLE, FS_FETCH, FS_HOLD, FS_DRAIN, FS_REDIRECT, FS_HALTED (3-bit).
- One natural sub-module: fetch_skid, the instruction holding register with valid/ready logic and the Fetch_Count counter.
- The FSM and PC-control pulse generation stay in the top level.

Test Plan:
- Clr, Run=1, PC_Out starting 8'h00 with PC model attached, memory Ack next cycle, data 16'h1234, Ready=1 -> Instr_Out=16'h1234, PC_Inc single pulse, next Mem_Addr=8'h01, Fetch_Count=1.
- Ready held 0 for 5 cycles after valid -> Instr_Out/Valid stable, single PC_Inc pulse, Mem_Req=0, Fetch_Count unchanged until Ready=1.
- Branch_Taken with Branch_Target=8'h40 while Mem_Req pending with Ack delayed 3 cycles -> PC_Load one cycle with Dest_Reg=8'h40, late data discarded (Valid stays 0), next Mem_Addr=8'h40.
- Branch_Taken in the first HOLD cycle (PC_Inc high) -> PC_Inc dropped, PC_Load=1, PC ends at target, never both pulses high.
- Memory returns 16'hF000 at addr 8'h03 -> instruction delivered, Halted=1 after transfer, no further Mem_Req for 20 cycles, Branch_Taken ignored.
- Clr asserted mid-FETCH asynchronously (between edges) -> outputs 0 immediately, State IDLE, subsequent Mem_Ack ignored; Run restarts fetch at current PC_Out.
